// File: rtl/serial_word_packer.sv
// Packs a qualified serial bit stream into WIDTH-bit words and hands each
// word out through a valid/ready output buffer, with a sticky drop flag.
//
// state   | meaning
// IDLE    | no partial word, bit_cnt = 0
// COLLECT | partial word in sreg, 1 <= bit_cnt <= WIDTH-1
module serial_word_packer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_en,
  input  logic             clr,
  output logic [WIDTH-1:0] word_out,
  output logic [CW-1:0]    ones_count,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overflow,
  output logic [CW-1:0]    bit_cnt
);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_next;
  logic             transfer;
  logic             complete;
  logic             load_word;
  logic             drop_word;

  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] w);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + CW'(w[i]);
    end
    return n;
  endfunction

  // sreg_next already includes the bit sampled at this edge, so on the
  // completing edge it is the full assembled word.
  always_comb begin
    sreg_next = MSB_FIRST ? {sreg[WIDTH-2:0], bit_in} : {bit_in, sreg[WIDTH-1:1]};
    transfer  = word_valid && word_ready;
    complete  = bit_en && !clr && (bit_cnt == LAST_CNT);
    load_word = complete && (!word_valid || word_ready);
    drop_word = complete && word_valid && !word_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sreg       <= '0;
      bit_cnt    <= '0;
      word_out   <= '0;
      ones_count <= '0;
      word_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (clr) begin
        state    <= IDLE;
        sreg     <= '0;
        bit_cnt  <= '0;
        overflow <= 1'b0;
      end else if (bit_en) begin
        case (state)
          IDLE: begin
            sreg    <= sreg_next;
            bit_cnt <= bit_cnt + CW'(1);
            state   <= COLLECT;
          end
          COLLECT: begin
            if (complete) begin
              sreg    <= '0;
              bit_cnt <= '0;
              state   <= IDLE;
            end else begin
              sreg    <= sreg_next;
              bit_cnt <= bit_cnt + CW'(1);
              state   <= COLLECT;
            end
          end
          default: begin
            sreg    <= '0;
            bit_cnt <= '0;
            state   <= IDLE;
          end
        endcase
      end

      // Output buffer: a completion may refill the slot on the same edge
      // the consumer empties it.
      if (load_word) begin
        word_out   <= sreg_next;
        ones_count <= popcount(sreg_next);
        word_valid <= 1'b1;
      end else if (transfer) begin
        word_valid <= 1'b0;
      end

      if (drop_word) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_word_packer.sv
// Bench for serial_word_packer: directed scenarios plus random traffic,
// both bit orders, checked against a queue-based reference model.
module tb_serial_word_packer;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          bit_in, bit_en, clr, word_ready;
  logic [W-1:0]  word_m, word_l;
  logic [CW-1:0] ones_m, ones_l, cnt_m, cnt_l;
  logic          valid_m, valid_l, ovf_m, ovf_l;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit           q_bits[$];
  logic         m_valid;
  logic         m_ovf;
  logic [W-1:0] m_word_m;
  logic [W-1:0] m_word_l;

  always #5 clk = ~clk;

  serial_word_packer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_en(bit_en), .clr(clr),
    .word_out(word_m), .ones_count(ones_m), .word_valid(valid_m),
    .word_ready(word_ready), .overflow(ovf_m), .bit_cnt(cnt_m)
  );

  serial_word_packer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_en(bit_en), .clr(clr),
    .word_out(word_l), .ones_count(ones_l), .word_valid(valid_l),
    .word_ready(word_ready), .overflow(ovf_l), .bit_cnt(cnt_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_bits.delete();
    m_valid  = 1'b0;
    m_ovf    = 1'b0;
    m_word_m = '0;
    m_word_l = '0;
  endtask

  // One clock edge of the reference, driven by the inputs as sampled.
  task automatic model_edge();
    logic         accept;
    logic [W-1:0] wm, wl;
    accept = m_valid && word_ready;
    if (accept) m_valid = 1'b0;
    if (clr) begin
      q_bits.delete();
      m_ovf = 1'b0;
    end else if (bit_en) begin
      q_bits.push_back(bit_in);
      if (q_bits.size() == W) begin
        wm = '0;
        wl = '0;
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = q_bits[i];
          wl[i]     = q_bits[i];
        end
        q_bits.delete();
        if (!m_valid) begin
          m_word_m = wm;
          m_word_l = wl;
          m_valid  = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("word_m",  32'(word_m),  32'(m_word_m));
    chk("word_l",  32'(word_l),  32'(m_word_l));
    chk("ones_m",  32'(ones_m),  32'($countones(m_word_m)));
    chk("ones_l",  32'(ones_l),  32'($countones(m_word_l)));
    chk("valid_m", 32'(valid_m), 32'(m_valid));
    chk("valid_l", 32'(valid_l), 32'(m_valid));
    chk("ovf_m",   32'(ovf_m),   32'(m_ovf));
    chk("ovf_l",   32'(ovf_l),   32'(m_ovf));
    chk("cnt_m",   32'(cnt_m),   q_bits.size());
    chk("cnt_l",   32'(cnt_l),   q_bits.size());
  endtask

  task automatic step(input logic b, input logic en, input logic c, input logic rdy);
    @(negedge clk);
    bit_in     = b;
    bit_en     = en;
    clr        = c;
    word_ready = rdy;
    @(posedge clk);
    model_edge();
    #1 check_all();
  endtask

  // Send a whole byte MSB-first in time; ready asserted only on the last edge if asked.
  task automatic send_byte(input logic [7:0] v, input logic rdy_last);
    for (int i = W - 1; i >= 0; i--) begin
      step(v[i], 1'b1, 1'b0, (i == 0) ? rdy_last : 1'b0);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_word_m"}, 32'(word_m), 0);
    chk({tag, "_word_l"}, 32'(word_l), 0);
    chk({tag, "_ones_m"}, 32'(ones_m), 0);
    chk({tag, "_valid"},  32'(valid_m | valid_l), 0);
    chk({tag, "_ovf"},    32'(ovf_m | ovf_l), 0);
    chk({tag, "_cnt"},    32'(cnt_m | cnt_l), 0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    bit_en     = 1'b0;
    clr        = 1'b0;
    word_ready = 1'b0;
    #2 rst = 1'b1;
    #1 check_zero_outputs("async_rst");
    model_reset();
    @(posedge clk);
    #1 check_zero_outputs("rst_held");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    bit_in     = 1'b0;
    bit_en     = 1'b0;
    clr        = 1'b0;
    word_ready = 1'b0;
    model_reset();
    #1 check_zero_outputs("reset");
    @(posedge clk);
    #1 check_zero_outputs("reset_edge");
    @(negedge clk);
    rst = 1'b0;

    // B2 stream: MSB-first gives B2, LSB-first gives 4D
    send_byte(8'hB2, 1'b0);
    chk("b2_word",   32'(word_m), 32'hB2);
    chk("4d_word",   32'(word_l), 32'h4D);
    chk("b2_ones",   32'(ones_m), 4);
    chk("4d_ones",   32'(ones_l), 4);
    chk("b2_valid",  32'(valid_m), 1);
    chk("b2_ovf",    32'(ovf_m), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("b2_taken",  32'(valid_m), 0);

    // enable toggling: only enabled edges count
    for (int i = 0; i < 16; i++) begin
      step(1'b1, (i % 2 == 0), 1'b0, 1'b0);
      if (i % 2 == 0 && i < 14) chk("toggle_cnt", 32'(cnt_m), 32'(i / 2 + 1));
    end
    chk("ff_word", 32'(word_m), 32'hFF);
    chk("ff_ones", 32'(ones_m), 8);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // back-to-back words with no consumer: second is dropped
    send_byte(8'hB2, 1'b0);
    send_byte(8'h0F, 1'b0);
    chk("drop_ovf",  32'(ovf_m), 1);
    chk("drop_word", 32'(word_m), 32'hB2);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("drop_taken", 32'(valid_m), 0);
    chk("ovf_sticky", 32'(ovf_m), 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_ovf", 32'(ovf_m), 0);

    // ready on the completing edge of the second word
    send_byte(8'hB2, 1'b0);
    send_byte(8'h0F, 1'b1);
    chk("swap_word",  32'(word_m), 32'h0F);
    chk("swap_valid", 32'(valid_m), 1);
    chk("swap_ovf",   32'(ovf_m), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // clr mid-word discards partial bits and the bit under clr
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("clr_cnt", 32'(cnt_m), 0);
    send_byte(8'h3C, 1'b0);
    chk("3c_word", 32'(word_m), 32'h3C);
    chk("3c_ones", 32'(ones_m), 4);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // async reset mid-word, then a clean word
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    async_reset();
    send_byte(8'hA6, 1'b0);
    chk("post_rst_word_m", 32'(word_m), 32'hA6);
    chk("post_rst_word_l", 32'(word_l), 32'h65);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 99) < 70),
           ($urandom_range(0, 99) < 3),
           ($urandom_range(0, 99) < 35));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
